// File: rtl/mux_scan_pkg.sv
`timescale 1ns/1ps
// Shared types and sizing for the mux scan sequencer and its settle timer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } scan_state_t;

    localparam int          NUM_CH     = 4;
    localparam int          SEL_W      = 2;
    localparam int unsigned MAX_SETTLE = 255;
    localparam int          CNT_W      = $clog2(MAX_SETTLE + 1);

    function automatic logic is_last_ch(input logic [SEL_W-1:0] sel_val);
        return sel_val == SEL_W'(NUM_CH - 1);
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
`timescale 1ns/1ps
// Settle timer: counts 0..SETTLE_CYCLES-1 while enabled, done flags the last count (combinational).
// No backpressure: load always wins, the count parks at its last value until reloaded.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign done = (r_count == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable && !done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
`timescale 1ns/1ps
// Steps a 4:1 mux select through channels 0..3, samples each after a settle window, emits a 4-bit snapshot.
// Snapshot valid 4*(SETTLE_CYCLES+1) edges after start; no backpressure, start is ignored while busy.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              mux_in,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] sample,
    output logic              sample_valid,
    output logic [7:0]        scan_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > MAX_SETTLE) begin : g_bad_settle
        $error("mux_scan_sequencer: SETTLE_CYCLES must be in 1..255");
    end

    scan_state_t       r_state;
    scan_state_t       w_next_state;
    logic              w_timer_load;
    logic              w_timer_en;
    logic              w_timer_done;
    logic              w_last_ch;

    logic [SEL_W-1:0]  r_sel;
    logic [NUM_CH-2:0] r_shadow;
    logic [NUM_CH-1:0] r_sample;
    logic [7:0]        r_scan_count;

    assign w_last_ch = is_last_ch(r_sel);
    assign w_timer_en = (r_state == SETTLE);

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_timer_load),
        .enable (w_timer_en),
        .done   (w_timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timer_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = SETTLE;
                    w_timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (w_timer_done) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_last_ch) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SETTLE;
                    w_timer_load = 1'b1;
                end
            end
            DONE: begin
                if (continuous) begin
                    w_next_state = SETTLE;
                    w_timer_load = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Channel 3 never lands in the shadow: it goes straight into the snapshot on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_shadow     <= '0;
            r_sample     <= '0;
            r_scan_count <= '0;
        end else begin
            case (r_state)
                CAPTURE: begin
                    for (int i = 0; i < NUM_CH - 1; i++) begin
                        if (r_sel == SEL_W'(i)) begin
                            r_shadow[i] <= mux_in;
                        end
                    end
                    if (w_last_ch) begin
                        r_sample <= {mux_in, r_shadow};
                    end else begin
                        r_sel <= r_sel + SEL_W'(1);
                    end
                end
                DONE: begin
                    r_sel        <= '0;
                    r_scan_count <= r_scan_count + 8'd1;
                end
                default: begin
                    r_sel <= r_sel;
                end
            endcase
        end
    end

    assign sel          = r_sel;
    assign busy         = (r_state != IDLE);
    assign sample       = r_sample;
    assign sample_valid = (r_state == DONE);
    assign scan_count   = r_scan_count;

endmodule
